param_int_issue_queue: RTL and testbench
========================================

// Module: param_int_issue_queue
// PURPOSE
// Parametrised, age-ordered integer issue queue between the dispatcher and the integer execution unit.
// - Holds up to DEPTH instructions and captures operands broadcast on the CDB, including in the
//   dispatch cycle.
// - Issues the OLDEST ready entry over a valid/ready handshake; can accept and issue in the same cycle.
// - A synchronous flush discards every entry (branch mispredict recovery).
// PARAMETERS
// DEPTH   8   number of entries, >=2
// DATA_W  32  operand data width
// TAG_W   6   physical-register tag width
// OPC_W   3   ALU opcode width
// PORTS
// clk              in   1                  rising-edge clock; the only clock
// reset_n          in   1                  asynchronous, active-low reset
// flush            in   1                  sync flush: invalidate all entries
// dispatch_valid   in   1                  dispatcher presents an instruction
// dispatch_ready   out  1                  queue accepts this cycle
// dispatch_rs_data in   DATA_W             rs operand data
// dispatch_rs_tag  in   TAG_W              rs producer tag
// dispatch_rs_val  in   1                  rs data already valid
// dispatch_rt_data in   DATA_W             rt operand data
// dispatch_rt_tag  in   TAG_W              rt producer tag
// dispatch_rt_val  in   1                  rt data already valid
// dispatch_opcode  in   OPC_W              ALU opcode
// dispatch_rd_tag  in   TAG_W              destination tag
// cdb_valid        in   1                  CDB broadcast valid
// cdb_tag          in   TAG_W              CDB result tag
// cdb_data         in   DATA_W             CDB result data
// issue_valid      out  1                  a ready entry is presented
// issue_ready      in   1                  execution unit accepts
// issue_rs_data    out  DATA_W             selected rs data
// issue_rt_data    out  DATA_W             selected rt data
// issue_rd_tag     out  TAG_W              selected rd tag
// issue_opcode     out  OPC_W              selected opcode
// occupancy        out  $clog2(DEPTH+1)    number of valid entries
// full / empty     out  1                  occupancy==DEPTH / occupancy==0
// BEHAVIOUR
// - Reset (reset_n=0, async): all entries invalid, occupancy=0, empty=1, full=0, dispatch_ready=1,
//   issue_valid=0, issue_* data=0.
// - Storage is compacted. Entry 0 is the oldest. Valid entries are always 0..occupancy-1.
// - Entry ready = valid & rs_val & rt_val.
// - Issue select:
//   - Lowest-index ready entry, combinational from state. issue_valid = any ready & !flush.
//   - issue_* = 0 when !issue_valid.
// - Issue fire = issue_valid & issue_ready. The fired entry is removed at the clock edge; entries
//   above it shift down by one.
// - dispatch_ready = !flush & (!full | issue_fire). This is a comb path from issue_ready.
// - Dispatch fire = dispatch_valid & dispatch_ready. The new entry is written at index
//   occupancy - issue_fire (after compaction).
// - occupancy(next) = occupancy + dispatch_fire - issue_fire. It never overflows or underflows.
// - CDB wakeup, per operand: if cdb_valid & !val & tag==cdb_tag, then data<=cdb_data and val<=1.
//   - The update follows the entry through a same-cycle shift.
//   - It is visible as ready in the next cycle. No same-cycle issue of a woken entry.
// - CDB dispatch bypass: a dispatched operand with val=0 and tag==cdb_tag in the same cycle is stored
//   with val=1 and data=cdb_data.
// - Operands with val=1 ignore the CDB.
// - The entry issuing this cycle needs no CDB update: both its operands are already valid.
// - Flush: all valid bits cleared at the next edge, occupancy=0. Flush has priority over dispatch and
//   issue; both are blocked in the flush cycle.
// - Full & issue fire & dispatch fire in the same cycle: occupancy stays DEPTH and no entry is lost.
// - Empty: issue_valid=0. A dispatch lands in entry 0 and may issue the next cycle if its operands
//   are valid.
// - Reset asserted mid-operation: state clears immediately; no handshake completes in that cycle.
// TESTING
// 1. Reset, then dispatch 3 entries, all operands valid:
//    -> issue order by rd_tag 1,2,3 with issue_ready=1; occupancy 3->0.
// 2. Entry A (rs_val=0, rs_tag=5) then B (ready):
//    -> B issues first.
//    -> cdb_valid, tag=5, data=0xDEAD -> A issues the next cycle with rs_data=0xDEAD.
// 3. Dispatch rt_val=0, rt_tag=9 while cdb_tag=9, data=0x1234 in the same cycle:
//    -> entry stored ready and issues the next cycle with rt_data=0x1234.
// 4. Fill to DEPTH=8 (full=1, dispatch_ready=0), then hold issue_ready=1 with dispatch_valid=1:
//    -> dispatch_ready=1, both fire, occupancy stays 8.
// 5. Occupancy 5, assert flush with dispatch_valid=1 and issue_ready=1:
//    -> no fire; next cycle occupancy=0, empty=1, issue_valid=0.
// 6. Assert reset_n=0 asynchronously mid-stream:
//    -> issue_valid=0 and occupancy=0 before the next clk edge.

Source files
------------

// File: rtl/param_int_issue_queue.sv
// Age-ordered integer issue queue: compacted storage with entry 0 the oldest.
// It captures CDB operands (including in the dispatch cycle) and issues the oldest
// ready entry over a valid/ready handshake.
module param_int_issue_queue #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 6,
  parameter int unsigned OPC_W  = 3
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         dispatch_valid,
  output logic                         dispatch_ready,
  input  logic [DATA_W-1:0]            dispatch_rs_data,
  input  logic [TAG_W-1:0]             dispatch_rs_tag,
  input  logic                         dispatch_rs_val,
  input  logic [DATA_W-1:0]            dispatch_rt_data,
  input  logic [TAG_W-1:0]             dispatch_rt_tag,
  input  logic                         dispatch_rt_val,
  input  logic [OPC_W-1:0]             dispatch_opcode,
  input  logic [TAG_W-1:0]             dispatch_rd_tag,
  input  logic                         cdb_valid,
  input  logic [TAG_W-1:0]             cdb_tag,
  input  logic [DATA_W-1:0]            cdb_data,
  output logic                         issue_valid,
  input  logic                         issue_ready,
  output logic [DATA_W-1:0]            issue_rs_data,
  output logic [DATA_W-1:0]            issue_rt_data,
  output logic [TAG_W-1:0]             issue_rd_tag,
  output logic [OPC_W-1:0]             issue_opcode,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         full,
  output logic                         empty
);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] r_rs_data [DEPTH];
  logic [TAG_W-1:0]  r_rs_tag  [DEPTH];
  logic              r_rs_val  [DEPTH];
  logic [DATA_W-1:0] r_rt_data [DEPTH];
  logic [TAG_W-1:0]  r_rt_tag  [DEPTH];
  logic              r_rt_val  [DEPTH];
  logic [OPC_W-1:0]  r_opcode  [DEPTH];
  logic [TAG_W-1:0]  r_rd_tag  [DEPTH];
  logic [OCC_W-1:0]  r_occ;

  // Woken view of storage; the extra top slot is a zero pad used as the shift source.
  logic [DATA_W-1:0] w_wk_rs_data [DEPTH+1];
  logic [TAG_W-1:0]  w_wk_rs_tag  [DEPTH+1];
  logic              w_wk_rs_val  [DEPTH+1];
  logic [DATA_W-1:0] w_wk_rt_data [DEPTH+1];
  logic [TAG_W-1:0]  w_wk_rt_tag  [DEPTH+1];
  logic              w_wk_rt_val  [DEPTH+1];
  logic [OPC_W-1:0]  w_wk_opcode  [DEPTH+1];
  logic [TAG_W-1:0]  w_wk_rd_tag  [DEPTH+1];

  logic [DATA_W-1:0] w_nx_rs_data [DEPTH];
  logic [TAG_W-1:0]  w_nx_rs_tag  [DEPTH];
  logic              w_nx_rs_val  [DEPTH];
  logic [DATA_W-1:0] w_nx_rt_data [DEPTH];
  logic [TAG_W-1:0]  w_nx_rt_tag  [DEPTH];
  logic              w_nx_rt_val  [DEPTH];
  logic [OPC_W-1:0]  w_nx_opcode  [DEPTH];
  logic [TAG_W-1:0]  w_nx_rd_tag  [DEPTH];

  logic              w_any;
  logic [IDX_W-1:0]  w_sel;
  logic              w_issue_fire;
  logic              w_disp_fire;
  logic              w_disp_rs_hit;
  logic              w_disp_rt_hit;
  logic [DEPTH-1:0]  w_shift;
  logic [OCC_W-1:0]  w_wr_idx;
  logic [OCC_W-1:0]  w_occ_nx;

  // Oldest-first pick of the lowest-index valid entry with both operands present.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!w_any && (OCC_W'(i) < r_occ) && r_rs_val[i] && r_rt_val[i]) begin
        w_any = 1'b1;
        w_sel = IDX_W'(i);
      end
    end
  end

  assign full           = (r_occ == OCC_W'(DEPTH));
  assign empty          = (r_occ == '0);
  assign occupancy      = r_occ;
  assign issue_valid    = w_any & ~flush;
  assign w_issue_fire   = issue_valid & issue_ready;
  assign dispatch_ready = ~flush & (~full | w_issue_fire);
  assign w_disp_fire    = dispatch_valid & dispatch_ready;
  assign issue_rs_data  = issue_valid ? r_rs_data[w_sel] : '0;
  assign issue_rt_data  = issue_valid ? r_rt_data[w_sel] : '0;
  assign issue_rd_tag   = issue_valid ? r_rd_tag[w_sel]  : '0;
  assign issue_opcode   = issue_valid ? r_opcode[w_sel]  : '0;
  assign w_disp_rs_hit  = cdb_valid & ~dispatch_rs_val & (dispatch_rs_tag == cdb_tag);
  assign w_disp_rt_hit  = cdb_valid & ~dispatch_rt_val & (dispatch_rt_tag == cdb_tag);

  // Apply the CDB broadcast to every waiting operand before any compaction shift.
  always_comb begin
    for (int i = 0; i < DEPTH + 1; i++) begin
      w_wk_rs_data[i] = '0;
      w_wk_rs_tag[i]  = '0;
      w_wk_rs_val[i]  = 1'b0;
      w_wk_rt_data[i] = '0;
      w_wk_rt_tag[i]  = '0;
      w_wk_rt_val[i]  = 1'b0;
      w_wk_opcode[i]  = '0;
      w_wk_rd_tag[i]  = '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      w_wk_rs_tag[i]  = r_rs_tag[i];
      w_wk_rt_tag[i]  = r_rt_tag[i];
      w_wk_opcode[i]  = r_opcode[i];
      w_wk_rd_tag[i]  = r_rd_tag[i];
      w_wk_rs_val[i]  = r_rs_val[i] | (cdb_valid & (r_rs_tag[i] == cdb_tag));
      w_wk_rt_val[i]  = r_rt_val[i] | (cdb_valid & (r_rt_tag[i] == cdb_tag));
      w_wk_rs_data[i] = (!r_rs_val[i] && cdb_valid && (r_rs_tag[i] == cdb_tag)) ? cdb_data : r_rs_data[i];
      w_wk_rt_data[i] = (!r_rt_val[i] && cdb_valid && (r_rt_tag[i] == cdb_tag)) ? cdb_data : r_rt_data[i];
    end
  end

  // Compact over the issued slot, then append the dispatched entry at the new tail.
  always_comb begin
    w_shift  = '0;
    w_wr_idx = r_occ - OCC_W'(w_issue_fire);
    w_occ_nx = flush ? '0 : (r_occ + OCC_W'(w_disp_fire) - OCC_W'(w_issue_fire));
    for (int i = 0; i < DEPTH; i++) begin
      w_shift[i]      = w_issue_fire && (IDX_W'(i) >= w_sel);
      w_nx_rs_data[i] = w_shift[i] ? w_wk_rs_data[i+1] : w_wk_rs_data[i];
      w_nx_rs_tag[i]  = w_shift[i] ? w_wk_rs_tag[i+1]  : w_wk_rs_tag[i];
      w_nx_rs_val[i]  = w_shift[i] ? w_wk_rs_val[i+1]  : w_wk_rs_val[i];
      w_nx_rt_data[i] = w_shift[i] ? w_wk_rt_data[i+1] : w_wk_rt_data[i];
      w_nx_rt_tag[i]  = w_shift[i] ? w_wk_rt_tag[i+1]  : w_wk_rt_tag[i];
      w_nx_rt_val[i]  = w_shift[i] ? w_wk_rt_val[i+1]  : w_wk_rt_val[i];
      w_nx_opcode[i]  = w_shift[i] ? w_wk_opcode[i+1]  : w_wk_opcode[i];
      w_nx_rd_tag[i]  = w_shift[i] ? w_wk_rd_tag[i+1]  : w_wk_rd_tag[i];
      if (w_disp_fire && (OCC_W'(i) == w_wr_idx)) begin
        w_nx_rs_data[i] = w_disp_rs_hit ? cdb_data : dispatch_rs_data;
        w_nx_rs_tag[i]  = dispatch_rs_tag;
        w_nx_rs_val[i]  = dispatch_rs_val | w_disp_rs_hit;
        w_nx_rt_data[i] = w_disp_rt_hit ? cdb_data : dispatch_rt_data;
        w_nx_rt_tag[i]  = dispatch_rt_tag;
        w_nx_rt_val[i]  = dispatch_rt_val | w_disp_rt_hit;
        w_nx_opcode[i]  = dispatch_opcode;
        w_nx_rd_tag[i]  = dispatch_rd_tag;
      end
    end
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_occ <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_rs_data[i] <= '0;
        r_rs_tag[i]  <= '0;
        r_rs_val[i]  <= 1'b0;
        r_rt_data[i] <= '0;
        r_rt_tag[i]  <= '0;
        r_rt_val[i]  <= 1'b0;
        r_opcode[i]  <= '0;
        r_rd_tag[i]  <= '0;
      end
    end else begin
      r_occ <= w_occ_nx;
      for (int i = 0; i < DEPTH; i++) begin
        r_rs_data[i] <= w_nx_rs_data[i];
        r_rs_tag[i]  <= w_nx_rs_tag[i];
        r_rs_val[i]  <= w_nx_rs_val[i];
        r_rt_data[i] <= w_nx_rt_data[i];
        r_rt_tag[i]  <= w_nx_rt_tag[i];
        r_rt_val[i]  <= w_nx_rt_val[i];
        r_opcode[i]  <= w_nx_opcode[i];
        r_rd_tag[i]  <= w_nx_rd_tag[i];
      end
    end
  end

endmodule

// File: tb/tb_param_int_issue_queue.sv
// Bench for param_int_issue_queue: a queue-based reference model predicts each cycle's
// handshake and status, and a scoreboard checks every issued instruction in order.
module tb_param_int_issue_queue;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TAG_W  = 6;
  localparam int unsigned OPC_W  = 3;
  localparam int unsigned OCC_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              flush = 1'b0;
  logic              dispatch_valid = 1'b0;
  logic              dispatch_ready;
  logic [DATA_W-1:0] dispatch_rs_data = '0;
  logic [TAG_W-1:0]  dispatch_rs_tag = '0;
  logic              dispatch_rs_val = 1'b0;
  logic [DATA_W-1:0] dispatch_rt_data = '0;
  logic [TAG_W-1:0]  dispatch_rt_tag = '0;
  logic              dispatch_rt_val = 1'b0;
  logic [OPC_W-1:0]  dispatch_opcode = '0;
  logic [TAG_W-1:0]  dispatch_rd_tag = '0;
  logic              cdb_valid = 1'b0;
  logic [TAG_W-1:0]  cdb_tag = '0;
  logic [DATA_W-1:0] cdb_data = '0;
  logic              issue_valid;
  logic              issue_ready = 1'b0;
  logic [DATA_W-1:0] issue_rs_data;
  logic [DATA_W-1:0] issue_rt_data;
  logic [TAG_W-1:0]  issue_rd_tag;
  logic [OPC_W-1:0]  issue_opcode;
  logic [OCC_W-1:0]  occupancy;
  logic              full;
  logic              empty;

  param_int_issue_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .OPC_W(OPC_W)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_rs_data(dispatch_rs_data), .dispatch_rs_tag(dispatch_rs_tag), .dispatch_rs_val(dispatch_rs_val),
    .dispatch_rt_data(dispatch_rt_data), .dispatch_rt_tag(dispatch_rt_tag), .dispatch_rt_val(dispatch_rt_val),
    .dispatch_opcode(dispatch_opcode), .dispatch_rd_tag(dispatch_rd_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs_data(issue_rs_data), .issue_rt_data(issue_rt_data),
    .issue_rd_tag(issue_rd_tag), .issue_opcode(issue_opcode),
    .occupancy(occupancy), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              rs_val;
    logic [TAG_W-1:0]  rs_tag;
    logic [DATA_W-1:0] rs_data;
    logic              rt_val;
    logic [TAG_W-1:0]  rt_tag;
    logic [DATA_W-1:0] rt_data;
    logic [OPC_W-1:0]  op;
    logic [TAG_W-1:0]  rd;
  } ent_t;

  ent_t mq[$];   // reference queue contents, oldest first
  ent_t sb[$];   // expected issue stream

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_disp(input logic rsv, input int rst, input logic [DATA_W-1:0] rsd,
                          input logic rtv, input int rtt, input logic [DATA_W-1:0] rtd, input int rd);
    dispatch_valid   = 1'b1;
    dispatch_rs_val  = rsv;
    dispatch_rs_tag  = TAG_W'(rst);
    dispatch_rs_data = rsd;
    dispatch_rt_val  = rtv;
    dispatch_rt_tag  = TAG_W'(rtt);
    dispatch_rt_data = rtd;
    dispatch_rd_tag  = TAG_W'(rd);
    dispatch_opcode  = OPC_W'(rd);
  endtask

  // Reference model: evaluated mid-cycle once inputs and DUT outputs have settled.
  initial begin : model
    int   sel;
    logic eiv, efi, edr, efd;
    ent_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!reset_n) begin
        mq.delete();
        sb.delete();
        chk("rst_occupancy", 64'(occupancy), 64'(0));
        chk("rst_issue_valid", 64'(issue_valid), 64'(0));
        chk("rst_empty", 64'(empty), 64'(1));
        chk("rst_full", 64'(full), 64'(0));
        chk("rst_dispatch_ready", 64'(dispatch_ready), 64'(!flush));
      end else begin
        sel = -1;
        for (int i = 0; i < mq.size(); i++)
          if (sel < 0 && mq[i].rs_val && mq[i].rt_val) sel = i;
        eiv = (sel >= 0) && !flush;
        efi = eiv && issue_ready;
        edr = !flush && ((mq.size() < DEPTH) || efi);
        efd = dispatch_valid && edr;
        chk("issue_valid", 64'(issue_valid), 64'(eiv));
        chk("dispatch_ready", 64'(dispatch_ready), 64'(edr));
        chk("occupancy", 64'(occupancy), 64'(mq.size()));
        chk("full", 64'(full), 64'(mq.size() == DEPTH));
        chk("empty", 64'(empty), 64'(mq.size() == 0));
        if (!eiv) chk("idle_issue_bus", 64'(issue_rs_data | issue_rt_data) | 64'(issue_rd_tag) | 64'(issue_opcode), 64'(0));
        if (efi) begin
          sb.push_back(mq[sel]);
          mq.delete(sel);
        end
        if (cdb_valid) begin
          for (int i = 0; i < mq.size(); i++) begin
            if (!mq[i].rs_val && mq[i].rs_tag == cdb_tag) begin mq[i].rs_val = 1'b1; mq[i].rs_data = cdb_data; end
            if (!mq[i].rt_val && mq[i].rt_tag == cdb_tag) begin mq[i].rt_val = 1'b1; mq[i].rt_data = cdb_data; end
          end
        end
        if (efd) begin
          e.rs_val  = dispatch_rs_val;  e.rs_tag = dispatch_rs_tag;  e.rs_data = dispatch_rs_data;
          e.rt_val  = dispatch_rt_val;  e.rt_tag = dispatch_rt_tag;  e.rt_data = dispatch_rt_data;
          e.op      = dispatch_opcode;  e.rd     = dispatch_rd_tag;
          if (cdb_valid && !e.rs_val && e.rs_tag == cdb_tag) begin e.rs_val = 1'b1; e.rs_data = cdb_data; end
          if (cdb_valid && !e.rt_val && e.rt_tag == cdb_tag) begin e.rt_val = 1'b1; e.rt_data = cdb_data; end
          mq.push_back(e);
        end
        if (flush) mq.delete();
      end
    end
  end

  // Monitor: every handshake the DUT completes must match the next expected issue.
  initial begin : monitor
    ent_t x;
    forever begin
      @(negedge clk);
      #3;
      if (reset_n && issue_valid && issue_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_issue: got rd %0h expected no issue at %0t", issue_rd_tag, $time);
        end else begin
          x = sb.pop_front();
          chk("issue_rd_tag", 64'(issue_rd_tag), 64'(x.rd));
          chk("issue_rs_data", 64'(issue_rs_data), 64'(x.rs_data));
          chk("issue_rt_data", 64'(issue_rt_data), 64'(x.rt_data));
          chk("issue_opcode", 64'(issue_opcode), 64'(x.op));
        end
      end
    end
  end

  initial begin : stim
    step(2);
    reset_n = 1'b1;

    // Three ready entries issue in age order.
    for (int i = 1; i <= 3; i++) begin
      set_disp(1'b1, 0, DATA_W'(32'h100 + i), 1'b1, 0, DATA_W'(32'h200 + i), i);
      step(1);
    end
    dispatch_valid = 1'b0;
    chk("t1_occ3", 64'(occupancy), 64'(3));
    issue_ready = 1'b1;
    step(3);
    chk("t1_occ0", 64'(occupancy), 64'(0));

    // Younger ready entry bypasses an older waiting one; CDB then wakes the older.
    issue_ready = 1'b0;
    set_disp(1'b0, 5, '0, 1'b1, 0, 32'h77, 4);
    step(1);
    set_disp(1'b1, 0, 32'h55, 1'b1, 0, 32'h66, 5);
    step(1);
    dispatch_valid = 1'b0;
    issue_ready    = 1'b1;
    step(1);
    chk("t2_occ1", 64'(occupancy), 64'(1));
    cdb_valid = 1'b1; cdb_tag = TAG_W'(5); cdb_data = 32'hDEAD;
    step(1);
    cdb_valid = 1'b0;
    step(1);
    chk("t2_occ0", 64'(occupancy), 64'(0));

    // Dispatch-cycle CDB bypass.
    set_disp(1'b1, 0, 32'h11, 1'b0, 9, '0, 6);
    cdb_valid = 1'b1; cdb_tag = TAG_W'(9); cdb_data = 32'h1234;
    step(1);
    dispatch_valid = 1'b0;
    cdb_valid      = 1'b0;
    step(1);
    chk("t3_occ0", 64'(occupancy), 64'(0));

    // Fill, stall while full, then issue and dispatch together.
    issue_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      set_disp(1'b1, 0, DATA_W'($urandom), 1'b1, 0, DATA_W'($urandom), 10 + i);
      step(1);
    end
    chk("t4_full", 64'(full), 64'(1));
    set_disp(1'b1, 0, 32'hAA, 1'b1, 0, 32'hBB, 30);
    step(1);
    chk("t4_occ_stall", 64'(occupancy), 64'(DEPTH));
    issue_ready = 1'b1;
    set_disp(1'b1, 0, 32'hCC, 1'b1, 0, 32'hDD, 31);
    step(1);
    chk("t4_occ_both", 64'(occupancy), 64'(DEPTH));
    dispatch_valid = 1'b0;
    step(DEPTH + 1);
    chk("t4_drained", 64'(occupancy), 64'(0));

    // Flush blocks both handshakes and clears the queue.
    issue_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_disp(1'b1, 0, DATA_W'($urandom), 1'b1, 0, DATA_W'($urandom), 40 + i);
      step(1);
    end
    chk("t5_occ5", 64'(occupancy), 64'(5));
    flush = 1'b1; issue_ready = 1'b1;
    set_disp(1'b1, 0, 32'h1, 1'b1, 0, 32'h2, 50);
    step(1);
    flush = 1'b0; dispatch_valid = 1'b0;
    chk("t5_occ0", 64'(occupancy), 64'(0));
    chk("t5_empty", 64'(empty), 64'(1));
    step(1);

    // Asynchronous reset mid-stream.
    issue_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_disp(1'b1, 0, DATA_W'($urandom), 1'b1, 0, DATA_W'($urandom), 20 + i);
      step(1);
    end
    issue_ready = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    chk("t6_async_occ", 64'(occupancy), 64'(0));
    chk("t6_async_iv", 64'(issue_valid), 64'(0));
    step(2);
    dispatch_valid = 1'b0;
    reset_n = 1'b1;
    step(1);

    // Random traffic with a small tag space so CDB matches are frequent.
    for (int c = 0; c < 3000; c++) begin
      dispatch_valid   = ($urandom_range(0, 3) != 0);
      dispatch_rs_val  = 1'($urandom_range(0, 1));
      dispatch_rs_tag  = TAG_W'($urandom_range(0, 7));
      dispatch_rs_data = DATA_W'($urandom);
      dispatch_rt_val  = 1'($urandom_range(0, 1));
      dispatch_rt_tag  = TAG_W'($urandom_range(0, 7));
      dispatch_rt_data = DATA_W'($urandom);
      dispatch_opcode  = OPC_W'($urandom);
      dispatch_rd_tag  = TAG_W'($urandom);
      cdb_valid        = ($urandom_range(0, 2) == 0);
      cdb_tag          = TAG_W'($urandom_range(0, 7));
      cdb_data         = DATA_W'($urandom);
      issue_ready      = ($urandom_range(0, 3) != 0);
      flush            = ($urandom_range(0, 99) == 0);
      step(1);
    end
    dispatch_valid = 1'b0;
    cdb_valid      = 1'b0;
    flush          = 1'b0;
    step(1);
    chk("sb_drained", 64'(sb.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
